prog_stream_loader: RTL and testbench

Upstream loader for the vector CPU's instruction-programming port. It accepts a byte stream (16-bit word-count header, then big-endian instruction words) over a valid/ready handshake. It assembles 32-bit instructions and drives `prog_en` / `inst_addr` / `prog_instruction` one word at a time. It holds the CPU in reset-equivalent hold until the image is fully written, so a host replaces the hand-written program sequence a bench uses today.

---
 rtl/prog_stream_loader.sv | 129 ++++++++++++
 tb/tb_prog_stream_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_stream_loader.sv
// Byte-stream program loader: 16-bit word-count header then big-endian words, one prog_en per word.
// Latency: first prog_en 7 cycles after start; 5 cycles/word best case; in_ready drops during ISSUE and outside the load.
module prog_stream_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        prog_en,
  output logic [31:0] inst_addr,
  output logic [31:0] prog_instruction,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, BYTES, ISSUE, DONE, ERROR} state_t;

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  state_t      state, state_nxt;
  logic [15:0] count;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic [31:0] addr;
  logic        accept;
  logic [31:0] hdr_word;
  logic [15:0] words_inc;

  assign in_ready  = (state == HDR_HI) || (state == HDR_LO) || (state == BYTES);
  assign accept    = in_valid && in_ready;
  assign hdr_word  = {16'd0, count[15:8], in_data};
  assign words_inc = words_loaded + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERROR: if (start) state_nxt = HDR_HI;
      HDR_HI:            if (accept) state_nxt = HDR_LO;
      HDR_LO: begin
        if (accept) begin
          if (hdr_word == 32'd0)   state_nxt = DONE;
          else if (hdr_word > MAX_W) state_nxt = ERROR;
          else                     state_nxt = BYTES;
        end
      end
      BYTES:   if (accept && byte_idx == 2'd3) state_nxt = ISSUE;
      ISSUE:   state_nxt = (words_inc == count) ? DONE : BYTES;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count            <= '0;
      byte_idx         <= '0;
      word_buf         <= '0;
      addr             <= '0;
      prog_en          <= 1'b0;
      inst_addr        <= '0;
      prog_instruction <= '0;
      cpu_hold         <= 1'b0;
      load_done        <= 1'b0;
      load_err         <= 1'b0;
      words_loaded     <= '0;
    end else begin
      prog_en <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
            byte_idx     <= '0;
            addr         <= BASE_ADDR;
            cpu_hold     <= 1'b1;
          end
        end
        HDR_HI: if (accept) count[15:8] <= in_data;
        HDR_LO: begin
          if (accept) begin
            count[7:0] <= in_data;
            if (state_nxt == DONE) begin
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end
            if (state_nxt == ERROR) begin
              load_err <= 1'b1;
              cpu_hold <= 1'b0;
            end
          end
        end
        BYTES: begin
          if (accept) begin
            // Shifting left keeps byte 0 in the top lane once all four have arrived.
            word_buf <= {word_buf[15:0], in_data};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              prog_en          <= 1'b1;
              inst_addr        <= addr;
              prog_instruction <= {word_buf, in_data};
            end
          end
        end
        ISSUE: begin
          addr         <= addr + 32'd4;
          words_loaded <= words_inc;
          byte_idx     <= '0;
          if (state_nxt == DONE) begin
            load_done <= 1'b1;
            cpu_hold  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_stream_loader.sv
// Directed bench for prog_stream_loader: two instances (base 0 and base FFFF_FFFC) sharing the byte stream.
module tb_prog_stream_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        rdy_a, rdy_b, pe_a, pe_b;
  logic [31:0] ia_a, ia_b, pi_a, pi_b;
  logic        hold_a, hold_b, done_a, done_b, err_a, err_b;
  logic [15:0] wl_a, wl_b;

  logic        sel_b = 1'b0;
  logic        rdy_sel;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          wide = 0;
  logic        prev_a = 1'b0, prev_b = 1'b0;
  logic [31:0] wa_addr[$], wa_data[$], wb_addr[$], wb_data[$];
  int          wa_cyc[$];
  logic [31:0] img[4];
  logic [31:0] exp_w[4];

  assign rdy_sel = sel_b ? rdy_b : rdy_a;

  always #5 clk = ~clk;

  prog_stream_loader u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_a), .prog_en(pe_a), .inst_addr(ia_a), .prog_instruction(pi_a),
    .cpu_hold(hold_a), .load_done(done_a), .load_err(err_a), .words_loaded(wl_a)
  );

  prog_stream_loader #(.BASE_ADDR(32'hFFFF_FFFC)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_b), .prog_en(pe_b), .inst_addr(ia_b), .prog_instruction(pi_b),
    .cpu_hold(hold_b), .load_done(done_b), .load_err(err_b), .words_loaded(wl_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every write strobe as the CPU would see it.
  always @(negedge clk) begin
    if (pe_a) begin
      wa_addr.push_back(ia_a);
      wa_data.push_back(pi_a);
      wa_cyc.push_back(cyc);
      if (prev_a) wide++;
    end
    if (pe_b) begin
      wb_addr.push_back(ia_b);
      wb_data.push_back(pi_b);
      if (prev_b) wide++;
    end
    prev_a = pe_a;
    prev_b = pe_b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    if (sel_b) start_b = 1'b1;
    else       start_a = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!rdy_sel && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'(n), 32'd0);
    @(posedge clk);
    @(negedge clk);
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic send_image(input logic [15:0] hdr, input int n, input bit gap);
    send_byte(hdr[15:8], gap);
    send_byte(hdr[7:0], gap);
    for (int i = 0; i < n; i++)
      for (int k = 3; k >= 0; k--) send_byte(img[i][8*k +: 8], gap);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!(sel_b ? done_b : done_a) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(sel_b ? done_b : done_a), 32'd1);
  endtask

  task automatic clear_log();
    wa_addr.delete(); wa_data.delete(); wa_cyc.delete();
    wb_addr.delete(); wb_data.delete();
    wide = 0;
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    exp_w[0] = 32'h2008_000A;  // addi $8, $0, 10
    exp_w[1] = 32'h2009_0014;  // addi $9, $0, 20
    exp_w[2] = 32'h200A_001E;  // addi $10, $0, 30
    exp_w[3] = 32'h200B_0028;  // addi $11, $0, 40

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(rdy_a), 32'd0);
    check("rst_prog_en", 32'(pe_a), 32'd0);
    check("rst_inst_addr", ia_a, 32'd0);
    check("rst_prog_instr", pi_a, 32'd0);
    check("rst_cpu_hold", 32'(hold_a), 32'd0);
    check("rst_flags", {30'd0, done_a, err_a}, 32'd0);
    check("rst_words", 32'(wl_a), 32'd0);
    check("rst_b_inst_addr", ia_b, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-BYTES after header 0x0003 and two data bytes
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    in_valid = 1'b0;
    check("mid_hold_before", 32'(hold_a), 32'd1);
    check("mid_ready_before", 32'(rdy_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_prog_en", 32'(pe_a), 32'd0);
    check("mid_rst_hold", 32'(hold_a), 32'd0);
    check("mid_rst_ready", 32'(rdy_a), 32'd0);
    check("mid_no_writes", 32'(wa_addr.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Four ADDI words, continuous valid
    for (int i = 0; i < 4; i++) img[i] = exp_w[i];
    clear_log();
    pulse_start();
    send_image(16'h0004, 4, 1'b0);
    wait_done("cont_done");
    check("cont_count", 32'(wa_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cont_addr%0d", i), wa_addr[i], 32'(4*i));
      check($sformatf("cont_data%0d", i), wa_data[i], exp_w[i]);
    end
    check("cont_first_latency", 32'(wa_cyc[0] - start_cyc), 32'd7);
    check("cont_word_period", 32'(wa_cyc[1] - wa_cyc[0]), 32'd5);
    check("cont_words", 32'(wl_a), 32'd4);
    check("cont_hold", 32'(hold_a), 32'd0);
    check("cont_err", 32'(err_a), 32'd0);
    check("cont_pulse_width", 32'(wide), 32'd0);

    // Same image with in_valid toggling every cycle
    clear_log();
    pulse_start();
    send_image(16'h0004, 4, 1'b1);
    wait_done("tog_done");
    check("tog_count", 32'(wa_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tog_addr%0d", i), wa_addr[i], 32'(4*i));
      check($sformatf("tog_data%0d", i), wa_data[i], exp_w[i]);
    end
    check("tog_words", 32'(wl_a), 32'd4);
    check("tog_pulse_width", 32'(wide), 32'd0);

    // Empty image completes straight from the header
    clear_log();
    pulse_start();
    send_image(16'h0000, 0, 1'b0);
    check("empty_done", 32'(done_a), 32'd1);
    check("empty_hold", 32'(hold_a), 32'd0);
    check("empty_words", 32'(wl_a), 32'd0);
    repeat (2) @(negedge clk);
    check("empty_no_writes", 32'(wa_addr.size()), 32'd0);

    // Oversized header: 0x0401 > 1024
    pulse_start();
    send_image(16'h0401, 0, 1'b0);
    repeat (2) @(negedge clk);
    check("big_err", 32'(err_a), 32'd1);
    check("big_done", 32'(done_a), 32'd0);
    check("big_ready", 32'(rdy_a), 32'd0);
    check("big_hold", 32'(hold_a), 32'd0);
    check("big_no_writes", 32'(wa_addr.size()), 32'd0);

    // start pulsed during BYTES is ignored
    clear_log();
    pulse_start();
    check("restart_clears_err", 32'(err_a), 32'd0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    in_valid = 1'b0;
    pulse_start();
    check("ign_still_loading", {30'd0, rdy_a, hold_a}, 32'd3);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    in_valid = 1'b0;
    wait_done("ign_done");
    check("ign_count", 32'(wa_addr.size()), 32'd1);
    check("ign_addr", wa_addr[0], 32'd0);
    check("ign_data", wa_data[0], 32'hDEAD_BEEF);
    check("ign_words", 32'(wl_a), 32'd1);

    // Address wrap from BASE_ADDR FFFF_FFFC
    sel_b = 1'b1;
    clear_log();
    img[0] = 32'h1122_3344;
    img[1] = 32'h5566_7788;
    pulse_start();
    send_image(16'h0002, 2, 1'b0);
    wait_done("wrap_done");
    check("wrap_count", 32'(wb_addr.size()), 32'd2);
    check("wrap_addr0", wb_addr[0], 32'hFFFF_FFFC);
    check("wrap_addr1", wb_addr[1], 32'h0000_0000);
    check("wrap_data0", wb_data[0], 32'h1122_3344);
    check("wrap_data1", wb_data[1], 32'h5566_7788);
    check("wrap_words", 32'(wl_b), 32'd2);
    check("wrap_a_untouched", 32'(wa_addr.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
